// File: rtl/stopwatch_lap_ctrl.sv
// stopwatch_lap_ctrl: two-button front end for the stopwatch core that
// turns start/stop and lap/reset buttons into 1-cycle start/stop/reset
// commands and queues lap times {minutes,seconds} in a show-ahead FIFO.
// Ports: clk, rst_n (async, active low); btn_ss, btn_lr raw buttons;
//   sw_minutes[7:0], sw_seconds[5:0] from the core; start/stop/reset
//   command pulses; lap_valid/lap_ready/lap_data[13:0] read port;
//   lap_count entries held; lap_overflow sticky drop flag.
// Option: define STOPWATCH_DEBOUNCE_EN to add a DEBOUNCE_CYCLES-long
//   stable-level filter after each button synchronizer.
module stopwatch_lap_ctrl #(
  parameter int LAP_DEPTH       = 8,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         btn_ss,
  input  logic                         btn_lr,
  input  logic [7:0]                   sw_minutes,
  input  logic [5:0]                   sw_seconds,
  output logic                         start,
  output logic                         stop,
  output logic                         reset,
  output logic                         lap_valid,
  input  logic                         lap_ready,
  output logic [13:0]                  lap_data,
  output logic [$clog2(LAP_DEPTH):0]   lap_count,
  output logic                         lap_overflow
);

  localparam int AW = $clog2(LAP_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    CLEAR
  } state_t;

  logic          r_ss_s1;
  logic          r_ss_s2;
  logic          r_lr_s1;
  logic          r_lr_s2;
  logic          r_ss_d;
  logic          r_lr_d;
  logic          w_ss_lvl;
  logic          w_lr_lvl;
  logic          w_ss_ev;
  logic          w_lr_ev;

  state_t        r_state;
  logic          r_start;
  logic          r_stop;
  logic          r_reset;
  logic          w_busy;

  logic [13:0]   r_mem [LAP_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_ovf;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_wr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ss_s1 <= 1'b0;
      r_ss_s2 <= 1'b0;
      r_lr_s1 <= 1'b0;
      r_lr_s2 <= 1'b0;
      r_ss_d  <= 1'b0;
      r_lr_d  <= 1'b0;
    end else begin
      r_ss_s1 <= btn_ss;
      r_ss_s2 <= r_ss_s1;
      r_lr_s1 <= btn_lr;
      r_lr_s2 <= r_lr_s1;
      r_ss_d  <= w_ss_lvl;
      r_lr_d  <= w_lr_lvl;
    end
  end

`ifdef STOPWATCH_DEBOUNCE_EN
  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);

  logic [DBW-1:0] r_ss_cnt;
  logic [DBW-1:0] r_lr_cnt;
  logic           r_ss_flt;
  logic           r_lr_flt;

  // The filtered level only follows the synchronized level once it has
  // differed for DEBOUNCE_CYCLES consecutive cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ss_cnt <= '0;
      r_lr_cnt <= '0;
      r_ss_flt <= 1'b0;
      r_lr_flt <= 1'b0;
    end else begin
      if (r_ss_s2 == r_ss_flt) begin
        r_ss_cnt <= '0;
      end else if (r_ss_cnt == DB_LAST) begin
        r_ss_cnt <= '0;
        r_ss_flt <= r_ss_s2;
      end else begin
        r_ss_cnt <= r_ss_cnt + 1'b1;
      end
      if (r_lr_s2 == r_lr_flt) begin
        r_lr_cnt <= '0;
      end else if (r_lr_cnt == DB_LAST) begin
        r_lr_cnt <= '0;
        r_lr_flt <= r_lr_s2;
      end else begin
        r_lr_cnt <= r_lr_cnt + 1'b1;
      end
    end
  end

  assign w_ss_lvl = r_ss_flt;
  assign w_lr_lvl = r_lr_flt;
`else
  assign w_ss_lvl = r_ss_s2;
  assign w_lr_lvl = r_lr_s2;
`endif

  // Start/stop has priority: a same-cycle lap/reset event is discarded.
  assign w_ss_ev = w_ss_lvl & ~r_ss_d;
  assign w_lr_ev = w_lr_lvl & ~r_lr_d & ~w_ss_ev;

  // A command in flight blocks the next command so pulses never abut.
  assign w_busy = r_start | r_stop | r_reset;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_start <= 1'b0;
      r_stop  <= 1'b0;
      r_reset <= 1'b0;
    end else begin
      r_start <= 1'b0;
      r_stop  <= 1'b0;
      r_reset <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_ss_ev && !w_busy) begin
            r_start <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          if (w_ss_ev && !w_busy) begin
            r_stop  <= 1'b1;
            r_state <= PAUSE;
          end
        end
        PAUSE: begin
          if (w_ss_ev && !w_busy) begin
            r_start <= 1'b1;
            r_state <= RUN;
          end else if (w_lr_ev && !w_busy) begin
            r_reset <= 1'b1;
            r_state <= CLEAR;
          end
        end
        CLEAR: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign w_push = (r_state == RUN) && w_lr_ev;
  assign w_pop  = lap_valid && lap_ready;
  assign w_full = (r_count == CW'(LAP_DEPTH));
  assign w_wr   = w_push && (!w_full || w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAP_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (r_state == CLEAR) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_wr) begin
        r_mem[r_wptr] <= {sw_minutes, sw_seconds};
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_push && w_full && !w_pop) begin
        r_ovf <= 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      if (w_wr && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_wr && w_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  assign start        = r_start;
  assign stop         = r_stop;
  assign reset        = r_reset;
  assign lap_valid    = (r_count != '0);
  assign lap_data     = r_mem[r_rptr];
  assign lap_count    = r_count;
  assign lap_overflow = r_ovf;

endmodule

// File: tb/tb_stopwatch_lap_ctrl.sv
// Directed bench for stopwatch_lap_ctrl: buttons, command timing,
// lap FIFO fill/drain/overflow, clear and mid-run reset.
module tb_stopwatch_lap_ctrl;

`ifdef STOPWATCH_DEBOUNCE_EN
  localparam int LAT = 19;
`else
  localparam int LAT = 3;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        btn_ss;
  logic        btn_lr;
  logic [7:0]  sw_minutes;
  logic [5:0]  sw_seconds;
  logic        start;
  logic        stop;
  logic        reset;
  logic        lap_valid;
  logic        lap_ready;
  logic [13:0] lap_data;
  logic [3:0]  lap_count;
  logic        lap_overflow;

  int n_cmp = 0;
  int n_err = 0;

  stopwatch_lap_ctrl #(
    .LAP_DEPTH(8),
    .DEBOUNCE_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_ss(btn_ss),
    .btn_lr(btn_lr),
    .sw_minutes(sw_minutes),
    .sw_seconds(sw_seconds),
    .start(start),
    .stop(stop),
    .reset(reset),
    .lap_valid(lap_valid),
    .lap_ready(lap_ready),
    .lap_data(lap_data),
    .lap_count(lap_count),
    .lap_overflow(lap_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Raise the chosen buttons at a negedge, hold them, and tally every
  // command pulse seen; idx is the first cycle any command appeared.
  task automatic press(input logic ss, input logic lr,
                       output int ns, output int np,
                       output int nr, output int idx);
    ns = 0;
    np = 0;
    nr = 0;
    idx = -1;
    @(negedge clk);
    btn_ss = ss;
    btn_lr = lr;
    for (int i = 1; i <= LAT + 4; i++) begin
      @(negedge clk);
      if (start) ns++;
      if (stop) np++;
      if (reset) nr++;
      if ((start || stop || reset) && idx < 0) idx = i;
      if (i == LAT + 1) begin
        btn_ss = 1'b0;
        btn_lr = 1'b0;
      end
    end
    repeat (LAT + 3) @(negedge clk);
  endtask

  task automatic set_sw(input int m, input int s);
    sw_minutes = 8'(m);
    sw_seconds = 6'(s);
  endtask

  int          ns;
  int          np;
  int          nr;
  int          idx;
  logic [13:0] exp_d;

  initial begin
    rst_n      = 1'b0;
    btn_ss     = 1'b0;
    btn_lr     = 1'b0;
    lap_ready  = 1'b0;
    set_sw(0, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_start", 32'(start), 0);
    chk("rst_stop", 32'(stop), 0);
    chk("rst_reset", 32'(reset), 0);
    chk("rst_valid", 32'(lap_valid), 0);
    chk("rst_count", 32'(lap_count), 0);
    chk("rst_ovf", 32'(lap_overflow), 0);
    chk("rst_data", 32'(lap_data), 0);

    press(1'b1, 1'b0, ns, np, nr, idx);
    chk("ss1_start", 32'(ns), 1);
    chk("ss1_other", 32'(np + nr), 0);
    chk("ss1_lat", 32'(idx), 32'(LAT));
    press(1'b1, 1'b0, ns, np, nr, idx);
    chk("ss2_stop", 32'(np), 1);
    chk("ss2_other", 32'(ns + nr), 0);
    chk("ss2_lat", 32'(idx), 32'(LAT));
    press(1'b1, 1'b0, ns, np, nr, idx);
    chk("ss3_start", 32'(ns), 1);
    chk("ss3_other", 32'(np + nr), 0);
    chk("ss3_lat", 32'(idx), 32'(LAT));

    set_sw(3, 25);
    press(1'b0, 1'b1, ns, np, nr, idx);
    chk("lap1_nocmd", 32'(ns + np + nr), 0);
    chk("lap1_count", 32'(lap_count), 1);
    chk("lap1_valid", 32'(lap_valid), 1);
    chk("lap1_data", 32'(lap_data), 32'h0D9);
    lap_ready = 1'b1;
    @(negedge clk);
    lap_ready = 1'b0;
    chk("pop1_count", 32'(lap_count), 0);
    chk("pop1_valid", 32'(lap_valid), 0);

    for (int i = 1; i <= 9; i++) begin
      set_sw(i, i * 3);
      press(1'b0, 1'b1, ns, np, nr, idx);
    end
    chk("full_count", 32'(lap_count), 8);
    chk("full_ovf", 32'(lap_overflow), 1);
    for (int k = 1; k <= 8; k++) begin
      exp_d = {8'(k), 6'(k * 3)};
      chk($sformatf("drain%0d_valid", k), 32'(lap_valid), 1);
      chk($sformatf("drain%0d_data", k), 32'(lap_data), 32'(exp_d));
      lap_ready = 1'b1;
      @(negedge clk);
      lap_ready = 1'b0;
    end
    chk("drain_count", 32'(lap_count), 0);
    chk("drain_valid", 32'(lap_valid), 0);
    lap_ready = 1'b1;
    @(negedge clk);
    lap_ready = 1'b0;
    chk("popempty_count", 32'(lap_count), 0);
    chk("drain_ovf", 32'(lap_overflow), 1);

    for (int i = 0; i < 3; i++) begin
      set_sw(10 + i, 40 + i);
      press(1'b0, 1'b1, ns, np, nr, idx);
    end
    chk("q3_count", 32'(lap_count), 3);
    press(1'b1, 1'b0, ns, np, nr, idx);
    chk("pause_stop", 32'(np), 1);
    press(1'b0, 1'b1, ns, np, nr, idx);
    chk("clr_reset", 32'(nr), 1);
    chk("clr_other", 32'(ns + np), 0);
    chk("clr_lat", 32'(idx), 32'(LAT));
    chk("clr_count", 32'(lap_count), 0);
    chk("clr_valid", 32'(lap_valid), 0);
    chk("clr_ovf", 32'(lap_overflow), 0);
    press(1'b0, 1'b1, ns, np, nr, idx);
    chk("idle_lr_nocmd", 32'(ns + np + nr), 0);
    chk("idle_lr_count", 32'(lap_count), 0);

    press(1'b1, 1'b0, ns, np, nr, idx);
    chk("run2_start", 32'(ns), 1);
    set_sw(7, 7);
    press(1'b1, 1'b1, ns, np, nr, idx);
    chk("both_stop", 32'(np), 1);
    chk("both_other", 32'(ns + nr), 0);
    chk("both_nolap", 32'(lap_count), 0);

    press(1'b1, 1'b0, ns, np, nr, idx);
    chk("run3_start", 32'(ns), 1);
    press(1'b0, 1'b1, ns, np, nr, idx);
    chk("run3_lap", 32'(lap_count), 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_count", 32'(lap_count), 0);
    chk("mid_rst_valid", 32'(lap_valid), 0);
    chk("mid_rst_cmd", 32'({start, stop, reset}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    press(1'b0, 1'b1, ns, np, nr, idx);
    chk("post_rst_nocmd", 32'(ns + np + nr), 0);
    chk("post_rst_count", 32'(lap_count), 0);

`ifdef STOPWATCH_DEBOUNCE_EN
    ns = 0;
    @(negedge clk);
    btn_ss = 1'b1;
    repeat (5) @(negedge clk);
    btn_ss = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (start) ns++;
    end
    chk("glitch_nostart", 32'(ns), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
